// File: rtl/sobel_window_gen_pkg.sv
// -----------------------------------------------------------------------------
// sobel_window_gen_pkg
// Shared constants for the Sobel window generator and its line buffers.
//   MAX_PIXEL_BITS : grayscale pixel width delivered by the control stage
//   WINDOW_SIZE    : side length of the square neighbourhood (3x3)
//   WINDOW_ELEMS   : number of pixels in one window
// -----------------------------------------------------------------------------
package sobel_window_gen_pkg;

    localparam int MAX_PIXEL_BITS = 8;
    localparam int WINDOW_SIZE    = 3;
    localparam int WINDOW_ELEMS   = WINDOW_SIZE * WINDOW_SIZE;

endpackage

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// Fixed-length shift register holding one image row. Each enabled cycle shifts
// i_data in and exposes the sample written DEPTH enables earlier on o_data,
// i.e. the pixel directly above the incoming one.
// Ports:
//   i_clk  : clock, rising edge
//   i_en   : shift enable (accepted pixel)
//   i_data : sample shifted in
//   o_data : oldest stored sample (combinational from the last stage)
// Storage is deliberately unreset; the consumer never exposes stale rows.
// -----------------------------------------------------------------------------
module sobel_line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
// Builds 3x3 pixel neighbourhoods from a raster pixel stream for a Sobel core.
// Two row-deep line buffers supply the two rows above the incoming pixel; a
// 3x3 register shifts left one column per accepted pixel.
// Ports:
//   clk_i          : clock, rising edge
//   reset_i        : asynchronous active-high reset
//   px_valid_i     : pixel accepted this cycle
//   px_data_i      : grayscale pixel
//   sof_i          : start of frame, qualified by px_valid_i
//   window_o       : element k=3*r+c at [k*MAX_PIXEL_BITS +: MAX_PIXEL_BITS]
//   window_valid_o : window_o is a complete in-frame window (1-cycle latency)
//   frame_done_o   : pulse alongside the final window of the frame
// -----------------------------------------------------------------------------
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   px_valid_i,
    input  logic [MAX_PIXEL_BITS-1:0]              px_data_i,
    input  logic                                   sof_i,
    output logic [WINDOW_ELEMS*MAX_PIXEL_BITS-1:0] window_o,
    output logic                                   window_valid_o,
    output logic                                   frame_done_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] MIN_COL  = CW'(WINDOW_SIZE - 1);
    localparam logic [RW-1:0] MIN_ROW  = RW'(WINDOW_SIZE - 1);

    logic [CW-1:0]             r_col;
    logic [RW-1:0]             r_row;
    logic [CW-1:0]             w_col;
    logic [RW-1:0]             w_row;
    logic [MAX_PIXEL_BITS-1:0] w_lb0;
    logic [MAX_PIXEL_BITS-1:0] w_lb1;
    logic [MAX_PIXEL_BITS-1:0] w_new_col [WINDOW_SIZE];
    logic                      w_win_ok;
    logic                      w_last_px;

    logic [WINDOW_ELEMS-1:0][MAX_PIXEL_BITS-1:0] r_win;
    logic                                        r_win_valid;
    logic                                        r_frame_done;

    // An accepted sof pixel is position (0,0) no matter where the counters are.
    assign w_col = sof_i ? '0 : r_col;
    assign w_row = sof_i ? '0 : r_row;

    // Column gating keeps windows from straddling a row wrap.
    assign w_win_ok  = (w_row >= MIN_ROW) && (w_col >= MIN_COL);
    assign w_last_px = (w_row == LAST_ROW) && (w_col == LAST_COL);

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (MAX_PIXEL_BITS)
    ) u_line_buf0 (
        .i_clk  (clk_i),
        .i_en   (px_valid_i),
        .i_data (px_data_i),
        .o_data (w_lb0)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (MAX_PIXEL_BITS)
    ) u_line_buf1 (
        .i_clk  (clk_i),
        .i_en   (px_valid_i),
        .i_data (w_lb0),
        .o_data (w_lb1)
    );

    // Incoming column, top to bottom.
    assign w_new_col[0] = w_lb1;
    assign w_new_col[1] = w_lb0;
    assign w_new_col[2] = px_data_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (px_valid_i) begin
            if (w_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (w_row == LAST_ROW) ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_win <= '0;
        end else if (px_valid_i) begin
            for (int r = 0; r < WINDOW_SIZE; r++) begin
                for (int c = 0; c < WINDOW_SIZE - 1; c++) begin
                    r_win[r*WINDOW_SIZE + c] <= r_win[r*WINDOW_SIZE + c + 1];
                end
                r_win[r*WINDOW_SIZE + WINDOW_SIZE - 1] <= w_new_col[r];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= px_valid_i && w_win_ok;
            r_frame_done <= px_valid_i && w_last_px;
        end
    end

    assign window_o       = r_win;
    assign window_valid_o = r_win_valid;
    assign frame_done_o   = r_frame_done;

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;
    import sobel_window_gen_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int B  = MAX_PIXEL_BITS;
    localparam int NB = WINDOW_ELEMS * B;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic          sof;
    logic [B-1:0]  dat;
    logic [NB-1:0] win;
    logic          wv;
    logic          fd;

    int checks   = 0;
    int failures = 0;

    // Reference model: image as written so far, current raster position.
    logic [B-1:0]  img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    int            n_win = 0;
    int            n_done = 0;
    logic [NB-1:0] first_win;
    logic [NB-1:0] ref_first;

    always #5 clk = ~clk;

    sobel_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .px_valid_i     (vld),
        .px_data_i      (dat),
        .sof_i          (sof),
        .window_o       (win),
        .window_valid_o (wv),
        .frame_done_o   (fd)
    );

    task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive on negedge, predict, sample 1ns after posedge.
    task automatic step(input bit v, input bit s, input logic [B-1:0] d);
        logic          exp_v;
        logic          exp_d;
        logic [NB-1:0] exp_w;
        @(negedge clk);
        vld = v;
        sof = s;
        dat = d;
        exp_v = 1'b0;
        exp_d = 1'b0;
        exp_w = '0;
        if (v) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = d;
            if (m_row >= 2 && m_col >= 2) begin
                exp_v = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_w[(3*i+j)*B +: B] = img[m_row-2+i][m_col-2+j];
            end
            exp_d = (m_row == H-1) && (m_col == W-1);
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H-1) ? 0 : m_row + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("window_valid", NB'(wv), NB'(exp_v));
        chk("frame_done", NB'(fd), NB'(exp_d));
        if (exp_v) chk("window", win, exp_w);
        if (wv) begin
            if (n_win == 0) first_win = win;
            n_win++;
        end
        if (fd) n_done++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld = 1'b0;
        sof = 1'b0;
        #1;
        chk("rst_valid", NB'(wv), '0);
        chk("rst_done", NB'(fd), '0);
        chk("rst_window", win, '0);
        @(negedge clk);
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
    endtask

    // Full frame of px=16*row+col; optional idle cycle (with junk sof) between pixels.
    task automatic frame(input bit toggle, input bit with_sof);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, with_sof && r == 0 && c == 0, B'(16*r + c));
                if (toggle) step(1'b0, 1'($urandom), B'($urandom));
            end
        end
    endtask

    task automatic clear_counts();
        n_win = 0;
        n_done = 0;
    endtask

    initial begin
        for (int k = 0; k < WINDOW_ELEMS; k++) ref_first[k*B +: B] = B'(16*(k/3) + (k%3));
        rst = 1'b1;
        vld = 1'b0;
        sof = 1'b0;
        dat = '0;
        #1;
        chk("reset_valid", NB'(wv), '0);
        chk("reset_done", NB'(fd), '0);
        chk("reset_window", win, '0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous frame
        clear_counts();
        frame(1'b0, 1'b1);
        chk("cont_wins", NB'(n_win), NB'(4));
        chk("cont_done", NB'(n_done), NB'(1));
        chk("cont_first", first_win, ref_first);

        // Toggling valid
        clear_counts();
        frame(1'b1, 1'b1);
        chk("toggle_wins", NB'(n_win), NB'(4));
        chk("toggle_done", NB'(n_done), NB'(1));
        chk("toggle_first", first_win, ref_first);

        // Partial frame then restart with sof
        clear_counts();
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, B'($urandom));
        frame(1'b0, 1'b1);
        chk("restart_wins", NB'(n_win), NB'(4));
        chk("restart_first", first_win, ref_first);

        // Reset mid-frame, next frame without sof
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, B'($urandom));
        do_reset();
        clear_counts();
        frame(1'b0, 1'b0);
        chk("postrst_wins", NB'(n_win), NB'(4));
        chk("postrst_done", NB'(n_done), NB'(1));
        chk("postrst_first", first_win, ref_first);

        // Back-to-back frames, sof only on the first
        clear_counts();
        frame(1'b0, 1'b1);
        frame(1'b0, 1'b0);
        chk("b2b_wins", NB'(n_win), NB'(8));
        chk("b2b_done", NB'(n_done), NB'(2));

        // Random traffic: gaps, sparse sof, occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, B'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
